// File: rtl/button_conditioner_if.sv
// Button conditioner bus: clock enable and raw buttons in, conditioned levels and pulses out.
interface button_conditioner_if #(
  parameter int unsigned N = 3
);
  logic         CE;
  logic [N-1:0] BTN_IN;
  logic [N-1:0] LEVEL;
  logic [N-1:0] PULSE;
  logic [N-1:0] RELEASE;

  modport master (output CE, output BTN_IN, input LEVEL, input PULSE, input RELEASE);
  modport slave  (input CE, input BTN_IN, output LEVEL, output PULSE, output RELEASE);
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces raw buttons, producing levels, press/release pulses
// and, on masked channels, hold-to-repeat press pulses.
module button_conditioner #(
  parameter int unsigned  N             = 3,
  parameter int unsigned  DB_CYCLES     = 16,
  parameter int unsigned  HOLD_CYCLES   = 256,
  parameter int unsigned  REPEAT_CYCLES = 64,
  parameter logic [N-1:0] REPEAT_MASK   = N'(3'b100)
) (
  input logic                 CLK,
  input logic                 CLR,
  button_conditioner_if.slave bus
);

  localparam int unsigned DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W   = (HC_MAX > 2) ? $clog2(HC_MAX) : 1;

  typedef enum logic {PH_HOLD, PH_REPEAT} phase_t;

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] rpt_c;
  logic [N-1:0] level_v;
  logic [N-1:0] pulse_v;
  logic [N-1:0] release_v;

  // Two-flop synchronizer, free-running regardless of CE
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.BTN_IN;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, release_q;
    logic            press_c, rel_c;

    always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        pulse_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        pulse_q   <= press_c | rpt_c[i];
        release_q <= rel_c;
      end
    end

    // Debounce: level follows the synchronized input only after DB_CYCLES enabled disagreeing cycles
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      press_c  = 1'b0;
      rel_c    = 1'b0;
      if (bus.CE) begin
        if (sync2_q[i] == level_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
          db_cnt_d = '0;
          level_d  = sync2_q[i];
          press_c  = sync2_q[i];
          rel_c    = ~sync2_q[i];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    if (REPEAT_MASK[i]) begin : g_rpt
      phase_t          phase_q, phase_d;
      logic [HC_W-1:0] hc_q, hc_d;
      logic            rpt_d;

      always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
          phase_q <= PH_HOLD;
          hc_q    <= '0;
        end else begin
          phase_q <= phase_d;
          hc_q    <= hc_d;
        end
      end

      // Released (or releasing) restarts the hold phase; the press edge itself sees level_q=0
      always_comb begin
        phase_d = phase_q;
        hc_d    = hc_q;
        rpt_d   = 1'b0;
        if (rel_c || !level_q) begin
          phase_d = PH_HOLD;
          hc_d    = '0;
        end else if (bus.CE) begin
          case (phase_q)
            PH_HOLD: begin
              if (hc_q == HC_W'(HOLD_CYCLES - 1)) begin
                rpt_d   = 1'b1;
                hc_d    = '0;
                phase_d = PH_REPEAT;
              end else begin
                hc_d = hc_q + 1'b1;
              end
            end
            PH_REPEAT: begin
              if (hc_q == HC_W'(REPEAT_CYCLES - 1)) begin
                rpt_d = 1'b1;
                hc_d  = '0;
              end else begin
                hc_d = hc_q + 1'b1;
              end
            end
          endcase
        end
      end

      assign rpt_c[i] = rpt_d;
    end else begin : g_norpt
      assign rpt_c[i] = 1'b0;
    end

    assign level_v[i]   = level_q;
    assign pulse_v[i]   = pulse_q;
    assign release_v[i] = release_q;
  end

  assign bus.LEVEL   = level_v;
  assign bus.PULSE   = pulse_v;
  assign bus.RELEASE = release_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed button scenarios push expected
// output events; a negedge monitor pops and compares whenever PULSE/RELEASE fire.
module tb_button_conditioner;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic [2:0] rel;
    logic [2:0] level;
  } ev_t;

  ev_t sb[$];

  button_conditioner_if #(.N(3)) bus ();

  button_conditioner #(
    .N(3), .DB_CYCLES(16), .HOLD_CYCLES(256), .REPEAT_CYCLES(64), .REPEAT_MASK(3'b100)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
    ev_t e;
    e.cyc = c; e.pulse = p; e.rel = r; e.level = l;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    do @(negedge CLK); while (cyc < c);
    #1;
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse/release output must match the next scoreboard entry
  always @(negedge CLK) begin
    ev_t e;
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event: expected pulse=%b release=%b at cyc %0d, not observed by cyc %0d",
               e.pulse, e.rel, e.cyc, cyc);
    end
    if ((bus.PULSE | bus.RELEASE) !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: pulse=%b release=%b level=%b at cyc %0d",
                 bus.PULSE, bus.RELEASE, bus.LEVEL, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.pulse !== bus.PULSE || e.rel !== bus.RELEASE || e.level !== bus.LEVEL) begin
          failures++;
          $display("FAIL event: got cyc=%0d pulse=%b release=%b level=%b expected cyc=%0d pulse=%b release=%b level=%b",
                   cyc, bus.PULSE, bus.RELEASE, bus.LEVEL, e.cyc, e.pulse, e.rel, e.level);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.CE     = 1'b1;
    bus.BTN_IN = 3'b111;

    // Reset with all buttons held: outputs stay 0, then one fresh press on all channels
    repeat (3) @(negedge CLK);
    #1;
    check3("reset_level", bus.LEVEL, 3'b000);
    check3("reset_pulse", bus.PULSE, 3'b000);
    check3("reset_release", bus.RELEASE, 3'b000);
    @(negedge CLK); #1;
    CLR = 1'b1;
    t = cyc;
    push(t + 18, 3'b111, 3'b000, 3'b111);
    goto(t + 20);
    check3("idle_level_high", bus.LEVEL, 3'b111);
    bus.BTN_IN = 3'b000;
    t = cyc;
    push(t + 18, 3'b000, 3'b111, 3'b000);
    goto(t + 30);

    // Clean press/release on channel 0 (no repeat)
    t = cyc;
    bus.BTN_IN = 3'b001;
    push(t + 18, 3'b001, 3'b000, 3'b001);
    goto(t + 17);
    check3("ch0_level_before", bus.LEVEL, 3'b000);
    goto(t + 40);
    check3("ch0_level_held", bus.LEVEL, 3'b001);
    bus.BTN_IN = 3'b000;
    push(t + 58, 3'b000, 3'b001, 3'b000);
    goto(t + 70);

    // Bounce on channel 1: 10 high / 3 low never survives debounce
    for (int j = 0; j < 100; j++) begin
      bus.BTN_IN[1] = ((j % 13) < 10);
      goto(cyc + 1);
    end
    bus.BTN_IN = 3'b000;
    goto(cyc + 30);
    check3("bounce_level", bus.LEVEL, 3'b000);

    // Auto-repeat on channel 2
    t = cyc;
    bus.BTN_IN = 3'b100;
    push(t + 18, 3'b100, 3'b000, 3'b100);
    push(t + 274, 3'b100, 3'b000, 3'b100);
    push(t + 338, 3'b100, 3'b000, 3'b100);
    push(t + 402, 3'b100, 3'b000, 3'b100);
    push(t + 466, 3'b100, 3'b000, 3'b100);
    push(t + 530, 3'b100, 3'b000, 3'b100);
    goto(t + 560);
    check3("repeat_level_held", bus.LEVEL, 3'b100);
    bus.BTN_IN = 3'b000;
    push(t + 578, 3'b000, 3'b100, 3'b000);
    goto(t + 620);

    // CE dropped for 20 cycles mid-debounce delays the press by exactly 20
    t = cyc;
    bus.BTN_IN = 3'b001;
    push(t + 38, 3'b001, 3'b000, 3'b001);
    goto(t + 5);
    bus.CE = 1'b0;
    goto(t + 18);
    check3("ce_frozen_level", bus.LEVEL, 3'b000);
    goto(t + 25);
    bus.CE = 1'b1;
    goto(t + 37);
    check3("ce_level_before", bus.LEVEL, 3'b000);
    goto(t + 50);
    bus.BTN_IN = 3'b000;
    push(t + 68, 3'b000, 3'b001, 3'b000);
    goto(t + 80);

    // Reset during repeat phase of channel 2, button held throughout
    t = cyc;
    bus.BTN_IN = 3'b100;
    push(t + 18, 3'b100, 3'b000, 3'b100);
    push(t + 274, 3'b100, 3'b000, 3'b100);
    goto(t + 300);
    check3("mid_level_before_clr", bus.LEVEL, 3'b100);
    CLR = 1'b0;
    #1;
    check3("mid_clr_level", bus.LEVEL, 3'b000);
    check3("mid_clr_pulse", bus.PULSE, 3'b000);
    goto(t + 303);
    CLR = 1'b1;
    push(t + 321, 3'b100, 3'b000, 3'b100);
    push(t + 577, 3'b100, 3'b000, 3'b100);
    goto(t + 600);
    bus.BTN_IN = 3'b000;
    push(t + 618, 3'b000, 3'b100, 3'b000);
    goto(t + 640);

    // Drain: every expected event must have been consumed
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d events left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
